// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer for the 8-bit MIPS-style core: program load into imem,
// then FETCH/DECODE/EXEC/WB stepping with halt, single-step and gated write enables.
module cpu_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  input  logic               start,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_done,
  output logic               load_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  input  logic               step_mode,
  input  logic               step,
  input  logic               finish,
  input  logic               reg_write_req,
  input  logic               dm_write_req,
  input  logic               flags_req,
  output logic               pc_clr,
  output logic               pc_en,
  output logic               ir_en,
  output logic               rf_we,
  output logic               dm_we,
  output logic               flags_we,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   retired,
  output logic [2:0]         state_dbg
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_FETCH     = 3'd2;
  localparam logic [2:0] S_DECODE    = 3'd3;
  localparam logic [2:0] S_EXEC      = 3'd4;
  localparam logic [2:0] S_WB        = 3'd5;
  localparam logic [2:0] S_STEP_WAIT = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] load_ptr, load_ptr_nxt;
  logic              fin_latch, fin_latch_nxt;
  logic [CNT_W-1:0]  retired_q, retired_nxt;

  logic idle_like;
  logic running;

  assign idle_like = (state == S_IDLE) || (state == S_HALT);
  assign running   = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);

  // Load port handshake: a word transfers on every cycle where load_valid and
  // load_ready are both high; load_ready is a pure function of state, so the
  // source may hold load_valid and see it consumed each cycle while in LOAD.
  always_comb begin
    state_nxt     = state;
    load_ptr_nxt  = load_ptr;
    fin_latch_nxt = fin_latch;
    retired_nxt   = retired_q;
    case (state)
      S_IDLE, S_HALT: begin
        if (load_req) begin
          state_nxt    = S_LOAD;
          load_ptr_nxt = '0;
        end else if (start) begin
          state_nxt   = S_FETCH;
          retired_nxt = '0;
        end
      end
      S_LOAD: begin
        if (load_valid) begin
          load_ptr_nxt = load_ptr + PTR_ONE;
        end
        // The top address ends the image even without load_done.
        if (load_done || (load_valid && (load_ptr == PTR_MAX))) begin
          state_nxt = S_IDLE;
        end
      end
      S_FETCH, S_DECODE, S_EXEC: begin
        state_nxt = state + 3'd1;
        if (finish) begin
          fin_latch_nxt = 1'b1;
        end
      end
      S_WB: begin
        if (retired_q != CNT_MAX) begin
          retired_nxt = retired_q + CNT_ONE;
        end
        if (fin_latch || finish) begin
          state_nxt     = S_HALT;
          fin_latch_nxt = 1'b0;
        end else if (step_mode) begin
          state_nxt = S_STEP_WAIT;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_STEP_WAIT: begin
        if (finish) begin
          state_nxt     = S_HALT;
          fin_latch_nxt = 1'b0;
        end else if (step || !step_mode) begin
          state_nxt = S_FETCH;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      load_ptr  <= '0;
      fin_latch <= 1'b0;
      retired_q <= '0;
    end else begin
      state     <= state_nxt;
      load_ptr  <= load_ptr_nxt;
      fin_latch <= fin_latch_nxt;
      retired_q <= retired_nxt;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign load_ready = (state == S_LOAD);
  assign imem_we    = (state == S_LOAD) && load_valid;
  assign imem_addr  = load_ptr;
  assign imem_wdata = load_data;

  assign pc_clr   = idle_like && start && !load_req;
  assign ir_en    = (state == S_FETCH);
  assign dm_we    = (state == S_EXEC) && dm_write_req;
  assign flags_we = (state == S_EXEC) && flags_req;
  assign rf_we    = (state == S_WB) && reg_write_req;
  assign pc_en    = (state == S_WB);

  assign busy      = running || (state == S_WB) || (state == S_STEP_WAIT);
  assign halted    = (state == S_HALT);
  assign retired   = retired_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: mode/phase reference model, per-cycle
// compare process, expected imem write queue and directed scenarios.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_req = 1'b0;
  logic        start = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = 16'h0;
  logic        load_done = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        finish = 1'b0;
  logic        reg_write_req = 1'b0;
  logic        dm_write_req = 1'b0;
  logic        flags_req = 1'b0;

  logic        load_ready, imem_we, pc_clr, pc_en, ir_en, rf_we, dm_we, flags_we, busy, halted;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [15:0] retired;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  logic [23:0] exp_q[$];

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .load_req(load_req), .start(start),
    .load_valid(load_valid), .load_data(load_data), .load_done(load_done),
    .load_ready(load_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .step_mode(step_mode), .step(step), .finish(finish),
    .reg_write_req(reg_write_req), .dm_write_req(dm_write_req), .flags_req(flags_req),
    .pc_clr(pc_clr), .pc_en(pc_en), .ir_en(ir_en), .rf_we(rf_we), .dm_we(dm_we),
    .flags_we(flags_we), .busy(busy), .halted(halted), .retired(retired),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: operating mode plus the phase of the current instruction.
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_STEP = 3, M_HALT = 4;
  int m_mode = M_IDLE;
  int m_phase = 0;
  int m_ptr = 0;
  bit m_fin = 1'b0;
  int m_ret = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_phase = 0; m_ptr = 0; m_fin = 1'b0; m_ret = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_HALT: begin
          if (load_req) begin m_mode = M_LOAD; m_ptr = 0; end
          else if (start) begin m_mode = M_RUN; m_phase = 0; m_ret = 0; end
        end
        M_LOAD: begin
          bit last;
          last = load_valid && (m_ptr == 255);
          if (load_valid) m_ptr = (m_ptr + 1) % 256;
          if (load_done || last) m_mode = M_IDLE;
        end
        M_RUN: begin
          if (m_phase < 3) begin
            if (finish) m_fin = 1'b1;
            m_phase++;
          end else begin
            if (m_ret < 65535) m_ret++;
            if (m_fin || finish) begin m_mode = M_HALT; m_fin = 1'b0; end
            else if (step_mode) m_mode = M_STEP;
            else m_phase = 0;
          end
        end
        M_STEP: begin
          if (finish) m_mode = M_HALT;
          else if (step || !step_mode) begin m_mode = M_RUN; m_phase = 0; end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // scoreboard / compare process
  always @(negedge clk) begin
    if (cmp_en) begin
      int es;
      bit run;
      logic [23:0] e;
      run = (m_mode == M_RUN);
      case (m_mode)
        M_IDLE: es = 0;
        M_LOAD: es = 1;
        M_RUN:  es = 2 + m_phase;
        M_STEP: es = 6;
        default: es = 7;
      endcase
      check("state", 32'(state_dbg), 32'(es));
      check("load_ready", 32'(load_ready), 32'(m_mode == M_LOAD));
      check("imem_we", 32'(imem_we), 32'((m_mode == M_LOAD) && load_valid));
      check("imem_addr", 32'(imem_addr), 32'(m_ptr));
      check("imem_wdata", 32'(imem_wdata), 32'(load_data));
      check("pc_clr", 32'(pc_clr), 32'((m_mode == M_IDLE || m_mode == M_HALT) && start && !load_req));
      check("ir_en", 32'(ir_en), 32'(run && m_phase == 0));
      check("dm_we", 32'(dm_we), 32'(run && m_phase == 2 && dm_write_req));
      check("flags_we", 32'(flags_we), 32'(run && m_phase == 2 && flags_req));
      check("rf_we", 32'(rf_we), 32'(run && m_phase == 3 && reg_write_req));
      check("pc_en", 32'(pc_en), 32'(run && m_phase == 3));
      check("busy", 32'(busy), 32'(run || m_mode == M_STEP));
      check("halted", 32'(halted), 32'(m_mode == M_HALT));
      check("retired", 32'(retired), 32'(m_ret));
      if (imem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("imem_unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(imem_addr), 32'(e[23:16]));
          check("wr_data", 32'(imem_wdata), 32'(e[15:0]));
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] target, input string name);
    int n;
    n = 0;
    while (state_dbg !== target && n < 64) begin
      tick();
      n++;
    end
    check(name, 32'(state_dbg), 32'(target));
  endtask

  task automatic drive_word(input bit v, input logic [15:0] d, input bit done, input logic [7:0] addr);
    load_valid = v;
    load_data  = d;
    load_done  = done;
    if (v) exp_q.push_back({addr, d});
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  bit   lv_tab[5]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] la_tab[5] = '{8'd0, 8'd1, 8'd0, 8'd2, 8'd3};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    reset = 1'b0;
    tick();

    // three words, then load_done with a fourth valid word (one idle gap)
    load_req = 1'b1; tick(); load_req = 1'b0;
    check("load_entered", 32'(load_ready), 32'd1);
    for (int i = 0; i < 5; i++) drive_word(lv_tab[i], 16'hA000 + 16'(i), i == 4, la_tab[i]);
    check("load4_idle", 32'(state_dbg), 32'd0);
    check("load4_q_empty", 32'(exp_q.size()), 32'd0);

    // full 256-word image without load_done, then a new load restarts at 0
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int i = 0; i < 256; i++) drive_word(1'b1, 16'h5000 + 16'(i), 1'b0, 8'(i));
    check("load256_auto_idle", 32'(state_dbg), 32'd0);
    load_req = 1'b1; tick(); load_req = 1'b0;
    check("reload_addr0", 32'(imem_addr), 32'd0);
    drive_word(1'b1, 16'hBEEF, 1'b1, 8'd0);
    check("reload_idle", 32'(state_dbg), 32'd0);

    // one instruction: pc_clr t0, ir_en t1, rf_we+pc_en t4; finish in FETCH halts after it
    reg_write_req = 1'b1;
    start = 1'b1;
    @(negedge clk); check("t0_pc_clr", 32'(pc_clr), 32'd1);
    tick(); start = 1'b0; finish = 1'b1;
    @(negedge clk); check("t1_ir_en", 32'(ir_en), 32'd1);
    tick(); finish = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("t4_rf_we", 32'(rf_we), 32'd1);
    check("t4_pc_en", 32'(pc_en), 32'd1);
    tick();
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_retired", 32'(retired), 32'd1);
    reg_write_req = 1'b0;

    // single-step: start then three step pulses
    step_mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_state(3'd6, "step_wait_first");
    check("step_ret_first", 32'(retired), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      repeat (3) tick();
      check("step_hold", 32'(state_dbg), 32'd6);
      check("step_hold_ret", 32'(retired), 32'(k));
      step = 1'b1; tick(); step = 1'b0;
      check("step_release", 32'(state_dbg), 32'd2);
      wait_state(3'd6, "step_wait_again");
      check("step_ret", 32'(retired), 32'(k + 1));
    end
    finish = 1'b1; tick(); finish = 1'b0;
    check("step_finish_halt", 32'(halted), 32'd1);
    check("step_total", 32'(retired), 32'd4);
    step_mode = 1'b0;

    // finish pulse in DECODE: WB still completes, then HALT; start restarts
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("in_decode", 32'(state_dbg), 32'd3);
    finish = 1'b1; tick(); finish = 1'b0;
    tick();
    check("wb_after_finish", 32'(pc_en), 32'd1);
    tick();
    check("fin_halted", 32'(halted), 32'd1);
    check("fin_retired", 32'(retired), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_fetch", 32'(state_dbg), 32'd2);

    // reset in EXEC with write requests pending
    wait_state(3'd5, "reach_wb");
    tick();
    wait_state(3'd4, "reach_exec");
    check("pre_rst_retired", 32'(retired), 32'd1);
    dm_write_req = 1'b1; flags_req = 1'b1;
    #1;
    check("exec_dm_we", 32'(dm_we), 32'd1);
    check("exec_flags_we", 32'(flags_we), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_flags_we", 32'(flags_we), 32'd0);
    check("rst_mid_state", 32'(state_dbg), 32'd0);
    check("rst_mid_retired", 32'(retired), 32'd0);
    tick();
    dm_write_req = 1'b0; flags_req = 1'b0;
    reset = 1'b0;
    tick();
    check("post_rst_idle", 32'(state_dbg), 32'd0);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
